uart_rx_byte: RTL and testbench

8N1 UART receiver, the receive-side counterpart of the link's transmit path. Samples the asynchronous rx line at mid-bit using a cycle counter derived from the system clock. Presents each byte through a valid/ready holding register with framing-error and overrun flags. Stays idle until the power-on enable from the startup delay is high.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_sync.sv | 42 ++++
 rtl/uart_rx_byte.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_byte.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART link (receiver and transmitter):
//   - uart_state_e    : frame-level FSM state encoding
//   - DATA_BITS       : payload bits per frame (8N1)
//   - cycles_per_bit(): system clocks per line bit, integer division
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // Truncating division: the bit period is rounded down, and the mid-bit
    // sampling point leaves enough margin for the resulting baud error.
    function automatic int cycles_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous rx line into the clock domain with two flops and
// adds a third flop so that a 1 -> 0 transition (start edge) can be seen.
// All flops reset to 1, the idle level of the line, so leaving reset never
// produces a false start edge on an idle line.
//
// Ports:
//   clk_i         in   system clock
//   rst_ni        in   synchronous active-low reset
//   rxd_i         in   raw asynchronous serial line
//   rxd_sync_o    out  synchronized line level
//   start_edge_o  out  one-cycle pulse: previous synced 1, current synced 0
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rxd_i,
    output logic rxd_sync_o,
    output logic start_edge_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rxd_sync_o   = sync2_q;
    assign start_edge_o = prev_q & ~sync2_q;

endmodule

// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
// 8N1 UART receiver. A cycle counter finds the mid-point of the start bit,
// then samples each data bit (LSB first) and the stop bit one bit period
// apart. Good frames are handed to the consumer through a valid/ready
// holding register; bad stop bits raise a one-cycle framing-error pulse.
//
// Handshake: rx_valid rises when a byte is loaded and stays high, with
// rx_data stable, until a rising edge where rx_valid && rx_ready; the byte is
// consumed on that edge. A byte that completes on the same edge as an accept
// replaces the accepted one without raising overrun.
//
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   synchronous active-low reset
//   en         in   startup enable; line ignored and frames aborted while low
//   uart_rxd   in   asynchronous serial line, idle high
//   rx_data    out  received byte
//   rx_valid   out  byte available, held until accepted
//   rx_ready   in   consumer accept
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  sticky, byte completed while the previous one was pending
//   rx_state   out  current FSM state (uart_state_e encoding), for debug
// -----------------------------------------------------------------------------
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       en,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic [1:0] rx_state
);

    localparam int BIT_CYC  = cycles_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_CYC = BIT_CYC / 2;

    localparam logic [15:0] BIT_LAST  = 16'(BIT_CYC - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CYC - 1);
    localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

    generate
        if ((BIT_CYC < 4) || (BIT_CYC >= 65536)) begin : g_bad_bit_cyc
            $error("uart_rx_byte: BIT_CYC must be in [4, 65535]");
        end
    endgenerate

    logic rxd_sync;
    logic start_edge;

    uart_rx_sync u_sync (
        .clk_i        (sys_clk),
        .rst_ni       (sys_rst_n),
        .rxd_i        (uart_rxd),
        .rxd_sync_o   (rxd_sync),
        .start_edge_o (start_edge)
    );

    uart_state_e state_q;
    logic [15:0] cyc_cnt_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        frame_err_q;
    logic        overrun_q;
    // Good stop bit seen last cycle; the holding register loads one edge later.
    logic        load_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            cyc_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            load_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            load_q      <= 1'b0;

            // Holding register: a new byte wins over an accept in the same cycle.
            if (load_q) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
                if (rx_valid_q && !rx_ready) begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (en && start_edge) begin
                        state_q   <= START;
                        cyc_cnt_q <= '0;
                    end
                end
                START: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (cyc_cnt_q == HALF_LAST) begin
                        cyc_cnt_q <= '0;
                        bit_idx_q <= '0;
                        // Line back high at mid start bit: treat as a glitch.
                        state_q   <= rxd_sync ? IDLE : DATA;
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 16'd1;
                    end
                end
                DATA: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (cyc_cnt_q == BIT_LAST) begin
                        cyc_cnt_q          <= '0;
                        shift_q[bit_idx_q] <= rxd_sync;
                        if (bit_idx_q == LAST_BIT) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 16'd1;
                    end
                end
                STOP: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (cyc_cnt_q == BIT_LAST) begin
                        cyc_cnt_q <= '0;
                        state_q   <= IDLE;
                        if (rxd_sync) begin
                            load_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cyc_cnt_q <= cyc_cnt_q + 16'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_state  = state_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
module tb_uart_rx_byte;

    localparam int BIT_CYC = 434;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       en;
    logic       uart_rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic [1:0] rx_state;

    int checks = 0;
    int errors = 0;

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    uart_rx_byte #(
        .CLK_FREQ (50000000),
        .BAUD     (115200)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .uart_rxd  (uart_rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_state  (rx_state)
    );

    // ---------------- monitors (sample on falling edge) ----------------
    int   cyc = 0;
    int   fe_high = 0;
    int   fe_rise = 0;
    int   start_seen = 0;
    int   deep_seen = 0;
    int   rise_cyc = -1;
    logic fe_prev = 1'b0;
    logic v_prev = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (frame_err) fe_high++;
        if (frame_err && !fe_prev) fe_rise++;
        fe_prev = frame_err;
        if (rx_valid && !v_prev) rise_cyc = cyc;
        v_prev = rx_valid;
        if (rx_state == 2'd1) start_seen++;
        if (rx_state == 2'd2 || rx_state == 2'd3) deep_seen++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int fall_cyc = 0;

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        uart_rxd = 1'b0;
        fall_cyc = cyc;
        tick(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            tick(BIT_CYC);
        end
        uart_rxd = stop_bit;
        tick(BIT_CYC);
        uart_rxd = 1'b1;
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int n;
        n = 0;
        while (!rx_valid && n < limit) begin
            tick(1);
            n++;
        end
        check(tag, {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int snap_fe_rise, snap_fe_high, snap_start, snap_deep, lat;
    logic [7:0] c3;

    initial begin
        sys_rst_n = 1'b0;
        en        = 1'b1;
        uart_rxd  = 1'b1;
        rx_ready  = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
        tick(2);

        // Reset state
        check("reset_rx_valid",  {31'd0, rx_valid},  32'd0);
        check("reset_rx_data",   {24'd0, rx_data},   32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_overrun",   {31'd0, overrun},   32'd0);
        check("reset_state",     {30'd0, rx_state},  32'd0);

        // 0x55, latency from line fall to rx_valid rise
        send_frame(8'h55, 1'b1);
        check("b55_valid", {31'd0, rx_valid}, 32'd1);
        check("b55_data",  {24'd0, rx_data},  32'h55);
        lat = rise_cyc - fall_cyc;
        check("b55_latency_window", {31'd0, (lat >= 4123 && lat <= 4129)}, 32'd1);
        check("b55_no_frame_err", fe_rise, 32'd0);
        accept();
        check("b55_accept_drop", {31'd0, rx_valid}, 32'd0);

        // 0xA3 then 0x0F with no idle gap; A3 is accepted mid-stream
        fork
            begin
                send_frame(8'hA3, 1'b1);
                send_frame(8'h0F, 1'b1);
            end
            begin
                wait_valid("bA3_valid_timeout", 6000);
                check("bA3_data", {24'd0, rx_data}, 32'hA3);
                rx_ready = 1'b1;
                tick(1);
                rx_ready = 1'b0;
                check("bA3_valid_falls", {31'd0, rx_valid}, 32'd0);
            end
        join
        check("b0F_valid",   {31'd0, rx_valid}, 32'd1);
        check("b0F_data",    {24'd0, rx_data},  32'h0F);
        check("b0F_overrun", {31'd0, overrun},  32'd0);
        accept();

        // Glitch: 100 low cycles never get past START
        snap_fe_rise = fe_rise;
        snap_start   = start_seen;
        snap_deep    = deep_seen;
        uart_rxd = 1'b0;
        tick(100);
        uart_rxd = 1'b1;
        tick(600);
        check("glitch_entered_start", {31'd0, (start_seen > snap_start)}, 32'd1);
        check("glitch_no_data_state", deep_seen - snap_deep, 32'd0);
        check("glitch_state_idle", {30'd0, rx_state}, 32'd0);
        check("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
        check("glitch_no_frame_err", fe_rise - snap_fe_rise, 32'd0);

        // 0x7E with stop bit low: one-cycle frame_err, nothing delivered
        snap_fe_rise = fe_rise;
        snap_fe_high = fe_high;
        send_frame(8'h7E, 1'b0);
        tick(20);
        check("fe_pulse_count",  fe_rise - snap_fe_rise, 32'd1);
        check("fe_pulse_width",  fe_high - snap_fe_high, 32'd1);
        check("fe_no_valid", {31'd0, rx_valid}, 32'd0);

        // 0x11 then 0x22 without accepting: overrun
        send_frame(8'h11, 1'b1);
        check("b11_data",    {24'd0, rx_data}, 32'h11);
        check("b11_overrun", {31'd0, overrun}, 32'd0);
        send_frame(8'h22, 1'b1);
        check("b22_overrun", {31'd0, overrun},  32'd1);
        check("b22_data",    {24'd0, rx_data},  32'h22);
        check("b22_valid",   {31'd0, rx_valid}, 32'd1);

        // One-cycle reset during bit 4 of 0xC3
        c3 = 8'hC3;
        uart_rxd = 1'b0;
        tick(BIT_CYC);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = c3[i];
            tick(BIT_CYC);
        end
        uart_rxd = c3[4];
        tick(200);
        sys_rst_n = 1'b0;
        tick(1);
        sys_rst_n = 1'b1;
        check("rst_mid_valid",   {31'd0, rx_valid},  32'd0);
        check("rst_mid_data",    {24'd0, rx_data},   32'd0);
        check("rst_mid_overrun", {31'd0, overrun},   32'd0);
        check("rst_mid_fe",      {31'd0, frame_err}, 32'd0);
        check("rst_mid_state",   {30'd0, rx_state},  32'd0);
        tick(BIT_CYC - 200);
        for (int i = 5; i < 8; i++) begin
            uart_rxd = c3[i];
            tick(BIT_CYC);
        end
        uart_rxd = 1'b1;
        tick(BIT_CYC);
        // The tail of the cut frame looks like a fresh start bit after reset;
        // let that frame finish and drop whatever it produced.
        tick(6 * BIT_CYC);
        if (rx_valid) accept();
        send_frame(8'h3C, 1'b1);
        check("b3C_valid",   {31'd0, rx_valid}, 32'd1);
        check("b3C_data",    {24'd0, rx_data},  32'h3C);
        check("b3C_overrun", {31'd0, overrun},  32'd0);
        accept();

        // Disabled receiver ignores a full frame
        en = 1'b0;
        snap_start = start_seen;
        send_frame(8'h99, 1'b1);
        tick(100);
        check("dis_no_valid", {31'd0, rx_valid}, 32'd0);
        check("dis_no_start", start_seen - snap_start, 32'd0);
        check("dis_data_kept", {24'd0, rx_data}, 32'h3C);
        en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
